serial_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/full_subtractor_structural.sv | 25 ++
 rtl/serial_subtractor.sv | 119 +++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_e;

   localparam int SUB_WIDTH_DEFAULT = 8;
   localparam int SUB_CNT_W_DEFAULT = $clog2(SUB_WIDTH_DEFAULT);

   // Bit-counter width for a given operand width (never narrower than one bit).
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_subtractor_structural.sv
// One-bit full subtractor built from gate primitives: diff = a^b^bin,
// borrow_out = (~a & b) | (~(a^b) & bin).
module full_subtractor_structural (
   input  logic a,
   input  logic b,
   input  logic borrow_in,
   output logic diff,
   output logic borrow_out
);

   logic a_n;
   logic a_xor_b;
   logic a_xnor_b;
   logic brw_gen;
   logic brw_prop;

   xor g_diff     (diff, a, b, borrow_in);
   not g_a_n      (a_n, a);
   and g_brw_gen  (brw_gen, a_n, b);
   xor g_axb      (a_xor_b, a, b);
   not g_axnb     (a_xnor_b, a_xor_b);
   and g_brw_prop (brw_prop, a_xnor_b, borrow_in);
   or  g_brw_out  (borrow_out, brw_gen, brw_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, WIDTH cycles per result.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   sub_state_e       state_reg;
   sub_state_e       state_next;
   logic [WIDTH-1:0] sa_reg;
   logic [WIDTH-1:0] sb_reg;
   logic [WIDTH-1:0] res_reg;
   logic             borrow_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             cell_d;
   logic             cell_bout;
   logic             accept;
   logic             last_bit;

   full_subtractor_structural u_cell (
      .a          (sa_reg[0]),
      .b          (sb_reg[0]),
      .borrow_in  (borrow_reg),
      .diff       (cell_d),
      .borrow_out (cell_bout)
   );

   assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
   assign last_bit = (state_reg == RUN) && (cnt_reg == LAST_BIT);

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: if (start) state_next = RUN;
         RUN: begin
            busy = 1'b1;
            if (cnt_reg == LAST_BIT) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = start ? RUN : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // The final bit goes straight into diff so the result is valid while done is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa_reg     <= '0;
         sb_reg     <= '0;
         res_reg    <= '0;
         borrow_reg <= 1'b0;
         cnt_reg    <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else if (accept) begin
         sa_reg     <= a;
         sb_reg     <= b;
         borrow_reg <= 1'b0;
         cnt_reg    <= '0;
      end else if (state_reg == RUN) begin
         sa_reg     <= sa_reg >> 1;
         sb_reg     <= sb_reg >> 1;
         res_reg    <= {cell_d, res_reg[WIDTH-1:1]};
         borrow_reg <= cell_bout;
         cnt_reg    <= cnt_reg + 1'b1;
         if (last_bit) begin
            diff       <= {cell_d, res_reg[WIDTH-1:1]};
            borrow_out <= cell_bout;
         end
      end
   end

`ifdef SERIAL_SUB_OVERFLOW_EN
   logic a_msb_reg;
   logic b_msb_reg;

   // The last processed bit is the result MSB, so overflow is decided on that edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb_reg <= 1'b0;
         b_msb_reg <= 1'b0;
         ovf       <= 1'b0;
      end else if (accept) begin
         a_msb_reg <= a[WIDTH-1];
         b_msb_reg <= b[WIDTH-1];
      end else if (last_bit) begin
         ovf <= (a_msb_reg != b_msb_reg) && (cell_d != a_msb_reg);
      end
   end
`endif

endmodule
